// File: rtl/peak_period_monitor.sv
// Peak period monitor: measures rise-to-rise intervals of the peak flag,
// tracks lock against the expected sweep period and flags lost peaks.
module peak_period_monitor #(
   parameter int EXP_PERIOD = 5002,
   parameter int TOL        = 4,
   parameter int TIMEOUT    = 8191,
   parameter int CW         = 14,
   parameter int LOCK_N     = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          peak_in,
   input  logic          clr_alarm,
   output logic [CW-1:0] period_out,
   output logic          period_valid,
   output logic          lock,
   output logic          alarm,
   output logic [15:0]   peak_count
);

   localparam int SW = $clog2(LOCK_N + 1);
   localparam logic [CW-1:0] EXP_C = CW'(EXP_PERIOD);
   localparam logic [CW-1:0] TOL_C = CW'(TOL);
   localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);
   localparam logic [SW-1:0] LCK_C = SW'(LOCK_N);

   typedef enum logic [1:0] {SYNC, MEASURE, ALARM} state_t;

   state_t        state_q, state_d;
   logic          peak_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] streak_q, streak_d;
   logic [SW-1:0] streak_inc;
   logic [CW-1:0] period_q, period_d;
   logic          valid_q, valid_d;
   logic          lock_q, lock_d;
   logic          alarm_q, alarm_d;
   logic [15:0]   pcount_q, pcount_d;
   logic          rise;
   logic [CW-1:0] diff;
   logic          in_tol;

   assign rise = peak_in & ~peak_q;

   // Larger minus smaller so the deviation never underflows.
   assign diff   = (cnt_q > EXP_C) ? (cnt_q - EXP_C) : (EXP_C - cnt_q);
   assign in_tol = (diff <= TOL_C);
   assign streak_inc = (streak_q == LCK_C) ? streak_q : streak_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      streak_d = streak_q;
      period_d = period_q;
      valid_d  = 1'b0;
      lock_d   = lock_q;
      alarm_d  = alarm_q;
      pcount_d = pcount_q + 16'(rise);
      unique case (state_q)
         SYNC: begin
            if (rise) begin
               cnt_d   = CW'(1);
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (rise) begin
               period_d = cnt_q;
               valid_d  = 1'b1;
               cnt_d    = CW'(1);
               if (in_tol) begin
                  streak_d = streak_inc;
                  if (streak_inc == LCK_C) lock_d = 1'b1;
               end else begin
                  streak_d = '0;
                  lock_d   = 1'b0;
               end
            end else if (cnt_q == TMO_C) begin
               state_d  = ALARM;
               alarm_d  = 1'b1;
               lock_d   = 1'b0;
               streak_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ALARM: begin
            if (clr_alarm) begin
               alarm_d = 1'b0;
               state_d = SYNC;
            end
         end
         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= SYNC;
         peak_q   <= 1'b0;
         cnt_q    <= '0;
         streak_q <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         lock_q   <= 1'b0;
         alarm_q  <= 1'b0;
         pcount_q <= '0;
      end else begin
         state_q  <= state_d;
         peak_q   <= peak_in;
         cnt_q    <= cnt_d;
         streak_q <= streak_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         lock_q   <= lock_d;
         alarm_q  <= alarm_d;
         pcount_q <= pcount_d;
      end
   end

   assign period_out   = period_q;
   assign period_valid = valid_q;
   assign lock         = lock_q;
   assign alarm        = alarm_q;
   assign peak_count   = pcount_q;

endmodule

// File: tb/tb_peak_period_monitor.sv
// Bench for peak_period_monitor: vector table plus hand-built alarm,
// recovery, timeout-boundary and mid-run reset sequences.
module tb_peak_period_monitor;

   localparam int CW = 14;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          peak_in = 1'b0;
   logic          clr_alarm = 1'b0;
   logic [CW-1:0] period_out;
   logic          period_valid;
   logic          lock;
   logic          alarm;
   logic [15:0]   peak_count;

   peak_period_monitor #(
      .EXP_PERIOD(5002), .TOL(4), .TIMEOUT(8191), .CW(CW), .LOCK_N(2)
   ) dut (
      .clk(clk), .rst(rst), .peak_in(peak_in), .clr_alarm(clr_alarm),
      .period_out(period_out), .period_valid(period_valid),
      .lock(lock), .alarm(alarm), .peak_count(peak_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int gap;
      int width;
      bit meas;
      bit exp_lock;
   } vec_t;

   vec_t tbl[7];
   int   expq[$];
   int   nvec = 0;
   int   nmis = 0;
   int   now = 0;
   int   last = 0;
   int   pc_exp = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, now);
      end
   endfunction

   // Scoreboard side: every period_valid must match the oldest pending period.
   task automatic mon();
      if (period_valid === 1'b1) begin
         if (expq.size() == 0) begin
            chk("unexpected_period_valid", 32'(period_out), 32'hFFFF_FFFF);
         end else begin
            chk("period_out", 32'(period_out), 32'(expq.pop_front()));
         end
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         now++;
         mon();
      end
   endtask

   task automatic rise_after(input int gap, input int width,
                             input bit meas, input bit exp_lock);
      if (last + gap > now) cycles(last + gap - now);
      peak_in = 1'b1;
      last = now;
      pc_exp++;
      if (meas) expq.push_back(gap);
      cycles(1);
      chk("lock", 32'(lock), 32'(exp_lock));
      chk("peak_count", 32'(peak_count), 32'(pc_exp));
      if (width > 1) begin
         cycles(width - 1);
         chk("peak_count_hold", 32'(peak_count), 32'(pc_exp));
      end
      peak_in = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_period_out"}, 32'(period_out), 0);
      chk({tag, "_period_valid"}, 32'(period_valid), 0);
      chk({tag, "_lock"}, 32'(lock), 0);
      chk({tag, "_alarm"}, 32'(alarm), 0);
      chk({tag, "_peak_count"}, 32'(peak_count), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{5002, 2, 1'b1, 1'b0};
      tbl[1] = '{5002, 2, 1'b1, 1'b1};
      tbl[2] = '{5007, 2, 1'b1, 1'b0};
      tbl[3] = '{4997, 2, 1'b1, 1'b0};
      tbl[4] = '{4998, 2, 1'b1, 1'b0};
      tbl[5] = '{4998, 2, 1'b1, 1'b1};
      tbl[6] = '{5006, 2, 1'b1, 1'b1};

      cycles(3);
      chk_zero("reset");
      rst = 1'b0;
      last = now;

      rise_after(10, 2, 1'b0, 1'b0);
      foreach (tbl[i]) rise_after(tbl[i].gap, tbl[i].width,
                                  tbl[i].meas, tbl[i].exp_lock);

      // Peaks stop: alarm exactly TIMEOUT cycles after the last rise.
      cycles(last + 8191 - now);
      chk("alarm_before_timeout", 32'(alarm), 0);
      cycles(1);
      chk("alarm_at_timeout", 32'(alarm), 1);
      chk("lock_at_timeout", 32'(lock), 0);

      for (int i = 0; i < 26; i++)
         rise_after((i == 0) ? 8200 : 4, 2, 1'b0, 1'b0);
      cycles(3);
      chk("alarm_sticky", 32'(alarm), 1);
      chk("period_out_kept", 32'(period_out), 5006);
      clr_alarm = 1'b1;
      cycles(1);
      clr_alarm = 1'b0;
      chk("alarm_cleared", 32'(alarm), 0);
      chk("period_out_after_clr", 32'(period_out), 5006);

      rise_after(10, 2, 1'b0, 1'b0);
      rise_after(5002, 2, 1'b1, 1'b0);
      rise_after(5002, 100, 1'b1, 1'b1);
      chk("peak_count_37", 32'(peak_count), 37);

      cycles(200);
      rst = 1'b1;
      cycles(1);
      chk_zero("midreset");
      rst = 1'b0;
      pc_exp = 0;
      last = now;

      rise_after(3, 2, 1'b0, 1'b0);
      rise_after(8191, 2, 1'b1, 1'b0);
      cycles(3);
      chk("alarm_after_boundary_rise", 32'(alarm), 0);
      chk("scoreboard_drained", 32'(expq.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
